// File: rtl/cabac_bin_decoder.sv
// rtl/cabac_bin_decoder.sv - CABAC arithmetic bin decoder (regular/bypass/terminate), optional CABAC_DEC_TERM_EN
module cabac_bin_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_mode,
    input  logic        req_mps,
    input  logic [31:0] four_lps,
    output logic        bin_valid,
    output logic        bin_val,
    output logic        bin_lps,
    output logic        end_of_slice,
    output logic [8:0]  range_o,
    output logic [8:0]  offset_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_DEC  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [8:0]  range_q, range_d;
    logic [8:0]  offset_q, offset_d;
    logic        bin_valid_q, bin_valid_d;
    logic        bin_val_q, bin_val_d;
    logic        bin_lps_q, bin_lps_d;
    logic        eos_q, eos_d;

    logic [7:0]  rlps;
    logic [8:0]  rmps;
    logic [9:0]  byp_off;
    logic [9:0]  byp_diff;
    logic        is_term;
    logic        dec_bin, dec_lps, dec_eos;
    logic [8:0]  r1, o1;
    logic        renorm_en, byp_used;
    logic [2:0]  shift;
    logic [14:0] norm_win;
    logic [8:0]  dec_range, dec_off;
    logic [4:0]  dec_consume;

    logic        req_fire, byte_fire, flush;
    logic [4:0]  consume;
    logic [15:0] base_buf;
    logic [4:0]  base_cnt;
    logic [23:0] app_win;

    assign byte_ready = (state_q != ST_IDLE) && (cnt_q <= 5'd8);
    // At least 7 buffered bits guarantees the largest renorm (6 bits) or a bypass can be served.
    assign req_ready  = (state_q == ST_DEC) && (cnt_q >= 5'd7) && !start;
    assign req_fire   = req_valid && req_ready;
    assign byte_fire  = byte_valid && byte_ready;

    assign rmps     = range_q - {1'b0, rlps};
    // Bypass doubles the offset before comparing, so it transiently needs a tenth bit.
    assign byp_off  = {offset_q, buf_q[15]};
    assign byp_diff = byp_off - {1'b0, range_q};

`ifdef CABAC_DEC_TERM_EN
    assign is_term = (req_mode == 2'b10);
`else
    assign is_term = 1'b0;
`endif

    // Pick the rLPS candidate for the current range quadrant.
    always_comb begin
        case (range_q[7:6])
            2'b00:   rlps = four_lps[31:24];
            2'b01:   rlps = four_lps[23:16];
            2'b10:   rlps = four_lps[15:8];
            default: rlps = four_lps[7:0];
        endcase
    end

    // Bin decision for the requested mode, before renormalisation.
    always_comb begin
        dec_bin   = 1'b0;
        dec_lps   = 1'b0;
        dec_eos   = 1'b0;
        r1        = range_q;
        o1        = offset_q;
        renorm_en = 1'b0;
        byp_used  = 1'b0;
        if (req_mode == 2'b00) begin
            renorm_en = 1'b1;
            if (offset_q >= rmps) begin
                dec_bin = ~req_mps;
                dec_lps = 1'b1;
                o1      = offset_q - rmps;
                r1      = {1'b0, rlps};
            end else begin
                dec_bin = req_mps;
                r1      = rmps;
            end
        end else if (is_term) begin
            r1 = range_q - 9'd2;
            if (offset_q >= r1) begin
                dec_bin = 1'b1;
                dec_eos = 1'b1;
            end else begin
                renorm_en = 1'b1;
            end
        end else begin
            byp_used = 1'b1;
            if (byp_off >= {1'b0, range_q}) begin
                dec_bin = 1'b1;
                o1      = byp_diff[8:0];
            end else begin
                o1      = byp_off[8:0];
            end
        end
    end

    // Single-cycle renormalisation: leading-zero count of the range, capped at 6.
    always_comb begin
        if (r1[8])      shift = 3'd0;
        else if (r1[7]) shift = 3'd1;
        else if (r1[6]) shift = 3'd2;
        else if (r1[5]) shift = 3'd3;
        else if (r1[4]) shift = 3'd4;
        else if (r1[3]) shift = 3'd5;
        else            shift = 3'd6;
        norm_win    = {o1, buf_q[15:10]} << shift;
        dec_range   = renorm_en ? (r1 << shift) : r1;
        dec_off     = renorm_en ? norm_win[14:6] : o1;
        dec_consume = renorm_en ? {2'b00, shift} : (byp_used ? 5'd1 : 5'd0);
    end

    // Next-state: FSM, range/offset update, result pulse and bit-buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        range_d     = range_q;
        offset_d    = offset_q;
        bin_valid_d = 1'b0;
        bin_val_d   = 1'b0;
        bin_lps_d   = 1'b0;
        eos_d       = 1'b0;
        consume     = 5'd0;
        flush       = 1'b0;
        if (start) begin
            state_d = ST_INIT;
            flush   = (state_q != ST_IDLE);
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q >= 5'd9) begin
                        offset_d = buf_q[15:7];
                        range_d  = 9'd510;
                        consume  = 5'd9;
                        state_d  = ST_DEC;
                    end
                end
                ST_DEC: begin
                    if (req_fire) begin
                        range_d     = dec_range;
                        offset_d    = dec_off;
                        consume     = dec_consume;
                        bin_valid_d = 1'b1;
                        bin_val_d   = dec_bin;
                        bin_lps_d   = dec_lps;
                        eos_d       = dec_eos;
                        if (dec_eos) state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
        base_buf = flush ? 16'd0 : (buf_q << consume);
        base_cnt = flush ? 5'd0 : (cnt_q - consume);
        // The incoming byte lands directly below whatever bits remain after consumption.
        app_win  = {byte_data, 16'd0} >> base_cnt;
        if (byte_fire) begin
            buf_d = base_buf | app_win[23:8];
            cnt_d = base_cnt + 5'd8;
        end else begin
            buf_d = base_buf;
            cnt_d = base_cnt;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            buf_q       <= 16'd0;
            cnt_q       <= 5'd0;
            range_q     <= 9'd510;
            offset_q    <= 9'd0;
            bin_valid_q <= 1'b0;
            bin_val_q   <= 1'b0;
            bin_lps_q   <= 1'b0;
            eos_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            range_q     <= range_d;
            offset_q    <= offset_d;
            bin_valid_q <= bin_valid_d;
            bin_val_q   <= bin_val_d;
            bin_lps_q   <= bin_lps_d;
            eos_q       <= eos_d;
        end
    end

    assign bin_valid    = bin_valid_q;
    assign bin_val      = bin_val_q;
    assign bin_lps      = bin_lps_q;
    assign end_of_slice = eos_q;
    assign range_o      = range_q;
    assign offset_o     = offset_q;

endmodule

// File: doc/cabac_bin_decoder.md
CABAC_BIN_DECODER -- requirements
Module: cabac_bin_decoder

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; begins slice initialisation.
REQ-005 byte_valid / byte_data / byte_ready  in / in[8] / out  bitstream byte handshake, MSB first; transfer on valid&ready.
REQ-006 req_valid / req_ready  in / out  bin request handshake; accept on valid&ready.
REQ-007 req_mode  input  2  00 regular, 01 bypass, 10 terminate, 11 reserved (treated as bypass).
REQ-008 req_mps  input  1  MPS value of the context for a regular bin.
REQ-009 four_lps  input  32  rLPS candidates: [31:24] for range[7:6]=00, [23:16] for 01, [15:8] for 10, [7:0] for 11.
REQ-010 bin_valid / bin_val / bin_lps  out / out / out  result pulse, decoded bin, 1 when a regular bin took the LPS path.
REQ-011 end_of_slice  output  1  one-cycle pulse when a terminate bin decodes 1.
REQ-012 range_o / offset_o  output  9 / 9  current range and offset registers, for observation.

Function
REQ-013 SHALL keep a 16-bit bit buffer with a 5-bit fill count (0..16); byte_ready=1 when count<=8, new byte appended below the existing bits; append and consume in the same cycle are allowed.
REQ-014 FSM states SHALL be IDLE, INIT, DEC; from IDLE, start moves to INIT; other requests in IDLE are not accepted.
REQ-015 INIT: when count>=9, load offset with the next 9 bits, range=510, go to DEC.
REQ-016 req_ready SHALL be 1 only in DEC with count>=7, so a worst-case 6-bit renorm never underflows.
REQ-017 Regular: rlps=four_lps slice selected by range[7:6]; rmps=range-rlps; if offset>=rmps then bin=!mps, bin_lps=1, offset-=rmps, range=rlps; else bin=mps, range=rmps.
REQ-018 Renorm SHALL take a single cycle: shift = number of left shifts bringing range to >=256 (0..6); range<<=shift; offset=(offset<<shift)|next shift bits; count-=shift.
REQ-019 Bypass: offset=(offset<<1)|next bit; if offset>=range then bin=1, offset-=range, else bin=0; range unchanged.
REQ-020 Terminate: range-=2; if offset>=range then bin=1, end_of_slice pulse, return to IDLE with no renorm; else bin=0, renorm as REQ-018.
REQ-021 Latency: bin_valid/bin_val/bin_lps SHALL be registered and pulse exactly one cycle after acceptance; no output backpressure; one bin per cycle sustained.
REQ-022 start received while in DEC SHALL abandon state, flush the bit buffer (count=0) and re-enter INIT.
REQ-023 All arithmetic SHALL be 9-bit unsigned; offset<range is a stream invariant and is not checked.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, range_o=510, offset_o=0, count=0, buffer=0, byte_ready=0, req_ready=0, bin_valid=0, bin_val=0, bin_lps=0, end_of_slice=0.
REQ-025 Reset asserted mid-operation SHALL drop any in-flight bin with no bin_valid pulse; after release the block waits in IDLE for start.

Configuration
REQ-026 Macro CABAC_DEC_TERM_EN: when defined, req_mode=10 decodes per REQ-020; when undefined, req_mode=10 is decoded as bypass, end_of_slice is tied 0, and the block never leaves DEC except on reset or start.

Verification
REQ-027 start, bytes 0x00,0x00 -> INIT completes, range_o=510, offset_o=0, req_ready=1.
REQ-028 After REQ-027: regular, mps=0, four_lps[7:0]=6 -> next cycle bin_valid=1, bin_val=0, bin_lps=0, range_o=504, no bits consumed.
REQ-029 start, bytes 0xFC,0x00; regular, mps=0, four_lps[7:0]=6 -> bin_val=1, bin_lps=1, range_o=384, offset_o=0, count decreases by 6.
REQ-030 From range 510, offset 0, next bit 1: bypass -> bin_val=0, offset_o=1; terminate (TERM_EN defined) -> bin_val=0, range_o=508, no end_of_slice.
REQ-031 byte_valid held high with no requests -> byte_ready drops once count>8 (two bytes after INIT); req_ready stays low while count<7.
REQ-032 rst_n pulsed low mid-stream with req_valid high -> all outputs at reset values next edge, no bin_valid, IDLE until start.
